hls_saturation_enh_udiv_seq: RTL



---
 rtl/hls_saturation_enh_pkg.sv | 16 +
 rtl/hls_saturation_enh_udiv_seq_if.sv | 29 ++
 rtl/hls_saturation_enh_udiv_step.sv | 19 +
 rtl/hls_saturation_enh_udiv_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/hls_saturation_enh_pkg.sv
// Shared types and default widths for the saturation-enhance unsigned divider.
package hls_saturation_enh_pkg;

    localparam int DIVIDEND_W_DEF = 27;
    localparam int DIVISOR_W_DEF  = 8;
    localparam int QUOTIENT_W_DEF = 19;
    localparam int CNT_W          = $clog2(DIVIDEND_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DZ,
        DONE
    } udiv_state_t;

endpackage

// File: rtl/hls_saturation_enh_udiv_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
interface hls_saturation_enh_udiv_seq_if
    import hls_saturation_enh_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF,
    parameter int QUOTIENT_W = QUOTIENT_W_DEF
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOTIENT_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  overflow;
    logic                  div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, overflow, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, overflow, div_zero
    );
endinterface

// File: rtl/hls_saturation_enh_udiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module hls_saturation_enh_udiv_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W:0]   diff;

    assign shifted = {rem_in, bit_in};
    assign q_bit   = shifted >= {2'b00, divisor};
    // only taken when shifted >= divisor, so the narrower subtract cannot wrap
    assign diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
    assign rem_out = q_bit ? diff : shifted[DIVISOR_W:0];
endmodule

// File: rtl/hls_saturation_enh_udiv_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, saturating quotient.
// Optional round-half-up quotient under `define HLS_SAT_UDIV_ROUND_EN (adds one cycle).
module hls_saturation_enh_udiv_seq
    import hls_saturation_enh_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF,
    parameter int QUOTIENT_W = QUOTIENT_W_DEF
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    hls_saturation_enh_udiv_seq_if.slave  bus
);
    localparam int CW = $clog2(DIVIDEND_W + 1);
`ifdef HLS_SAT_UDIV_ROUND_EN
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W);
`else
    localparam logic [CW-1:0] LAST = CW'(DIVIDEND_W - 1);
`endif

    udiv_state_t state, nxt;

    logic [DIVIDEND_W-1:0] dvd, quo, quo_nx;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W:0]    rem, rem_nx;
    logic [CW-1:0]         cnt;
    logic                  q_bit;

    logic [DIVIDEND_W:0]   fin;
    logic [DIVISOR_W-1:0]  fin_rem;
    logic                  fin_ovf;
    logic [QUOTIENT_W-1:0] fin_q;

    logic [QUOTIENT_W-1:0] q_o;
    logic [DIVISOR_W-1:0]  r_o;
    logic                  ovf_o, dz_o;

    hls_saturation_enh_udiv_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem_in  (rem),
        .bit_in  (dvd[DIVIDEND_W-1]),
        .divisor (dvs),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    assign quo_nx = {quo[DIVIDEND_W-2:0], q_bit};

    always_comb begin
`ifdef HLS_SAT_UDIV_ROUND_EN
        // extra cycle: quo/rem already hold the truncated result
        fin     = {1'b0, quo} + {{DIVIDEND_W{1'b0}}, ({rem, 1'b0} >= {2'b00, dvs})};
        fin_rem = rem[DIVISOR_W-1:0];
`else
        fin     = {1'b0, quo_nx};
        fin_rem = rem_nx[DIVISOR_W-1:0];
`endif
        fin_ovf = |fin[DIVIDEND_W:QUOTIENT_W];
        fin_q   = fin_ovf ? {QUOTIENT_W{1'b1}} : fin[QUOTIENT_W-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (bus.in_valid) nxt = (bus.divisor == '0) ? DZ : CALC;
            CALC: if (cnt == LAST) nxt = DONE;
            DZ:   nxt = DONE;
            DONE: if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dvd   <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_o   <= '0;
            r_o   <= '0;
            ovf_o <= 1'b0;
            dz_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    dvd <= bus.dividend;
                    dvs <= bus.divisor;
                    quo <= '0;
                    rem <= '0;
                    cnt <= '0;
                end
                CALC: begin
                    if (cnt < CW'(DIVIDEND_W)) begin
                        dvd <= dvd << 1;
                        quo <= quo_nx;
                        rem <= rem_nx;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        q_o   <= fin_q;
                        r_o   <= fin_rem;
                        ovf_o <= fin_ovf;
                        dz_o  <= 1'b0;
                    end
                end
                DZ: begin
                    q_o   <= '1;
                    r_o   <= '0;
                    ovf_o <= 1'b0;
                    dz_o  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = q_o;
    assign bus.remainder = r_o;
    assign bus.overflow  = ovf_o;
    assign bus.div_zero  = dz_o;
endmodule
